// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone-B3 slave interrupt controller.
// Each source is synchronised, then edge- or level-detected according to
// its 2-bit MODE field. A detected event sets a sticky pending bit, and
// pending & enable drive the registered irq vector, irq_any and the
// lowest-index irq_id. Registers: STATUS (W1C), ENABLE, MODE, RAW.
module wb_irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc,
  input  logic             wb_stb,
  input  logic             wb_we,
  input  logic [31:0]      wb_adr,
  input  logic [3:0]       wb_sel,
  input  logic [31:0]      wb_wdata,
  output logic [31:0]      wb_rdata,
  output logic             wb_ack,
  output logic             wb_err,
  output logic             wb_rty,
  input  logic [N_SRC-1:0] src,
  output logic [N_SRC-1:0] irq,
  output logic             irq_any,
  output logic [3:0]       irq_id
);

  localparam int MODE_W = 2 * N_SRC;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_RISE   = 2'b01,
    MODE_FALL   = 2'b10,
    MODE_CHANGE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_ENABLE = 2'd1,
    REG_MODE   = 2'd2,
    REG_RAW    = 2'd3
  } reg_e;

  logic [N_SRC-1:0]  s;
  logic [N_SRC-1:0]  last;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  enable;
  logic [N_SRC-1:0]  pending_next;
  logic [N_SRC-1:0]  enable_next;
  logic [N_SRC-1:0]  set_evt;
  logic [N_SRC-1:0]  clr_mask;
  logic [N_SRC-1:0]  masked;
  logic [MODE_W-1:0] mode;
  logic [MODE_W-1:0] mode_next;
  logic [31:0]       byte_mask;
  logic [31:0]       rdata_next;
  logic [3:0]        id_next;
  logic              access;
  logic              wr;
  reg_e              reg_sel;
  mode_e             md;
  logic              unused_bits;

  // A new access is accepted only while ack is low, which gives one wait
  // state per transfer and makes held strobes ack every other cycle.
  assign access  = wb_cyc & wb_stb & ~wb_ack;
  assign wr      = access & wb_we;
  assign reg_sel = reg_e'(wb_adr[3:2]);
  assign masked  = pending & enable;
  assign wb_err  = 1'b0;
  assign wb_rty  = 1'b0;

  // Address bits outside [3:2] and unused data lanes are intentionally ignored.
  assign unused_bits = ^{wb_adr[31:4], wb_adr[1:0], wb_wdata, byte_mask};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = src;
    end else begin : g_sync
      logic [N_SRC-1:0] sync_q [SYNC_STAGES];

      // Shift raw sources through the synchroniser chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= src;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Expand the byte-lane selects into a 32-bit write mask.
  always_comb begin
    byte_mask = '0;
    for (int b = 0; b < 4; b++) byte_mask[8*b +: 8] = {8{wb_sel[b]}};
  end

  // Decode register writes into new ENABLE/MODE values and a W1C mask.
  always_comb begin
    enable_next = enable;
    mode_next   = mode;
    clr_mask    = '0;
    if (wr) begin
      case (reg_sel)
        REG_STATUS: clr_mask = wb_wdata[N_SRC-1:0] & byte_mask[N_SRC-1:0];
        REG_ENABLE: enable_next = (enable & ~byte_mask[N_SRC-1:0]) |
                                  (wb_wdata[N_SRC-1:0] & byte_mask[N_SRC-1:0]);
        REG_MODE:   mode_next = (mode & ~byte_mask[MODE_W-1:0]) |
                                (wb_wdata[MODE_W-1:0] & byte_mask[MODE_W-1:0]);
        default:    ;
      endcase
    end
  end

  // Per-source event detection; a set event overrides a same-cycle W1C.
  always_comb begin
    set_evt      = '0;
    pending_next = pending;
    md           = MODE_LEVEL;
    for (int i = 0; i < N_SRC; i++) begin
      md = mode_e'(mode[2*i +: 2]);
      case (md)
        MODE_LEVEL:  pending_next[i] = s[i];
        MODE_RISE:   set_evt[i] = s[i] & ~last[i];
        MODE_FALL:   set_evt[i] = ~s[i] & last[i];
        MODE_CHANGE: set_evt[i] = s[i] ^ last[i];
        default:     ;
      endcase
      if (md != MODE_LEVEL) pending_next[i] = set_evt[i] | (pending[i] & ~clr_mask[i]);
    end
  end

  // Read multiplexer; unused high bits read as zero.
  always_comb begin
    rdata_next = '0;
    case (reg_sel)
      REG_STATUS: rdata_next[N_SRC-1:0]  = pending;
      REG_ENABLE: rdata_next[N_SRC-1:0]  = enable;
      REG_MODE:   rdata_next[MODE_W-1:0] = mode;
      REG_RAW:    rdata_next[N_SRC-1:0]  = s;
      default:    ;
    endcase
  end

  // Fixed priority: scanning downwards leaves the lowest asserted index.
  always_comb begin
    id_next = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) id_next = 4'(i);
    end
  end

  // Controller state; last tracks s in every mode so MODE changes never fake an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last    <= '0;
      pending <= '0;
      enable  <= '0;
      mode    <= '0;
    end else begin
      last    <= s;
      pending <= pending_next;
      enable  <= enable_next;
      mode    <= mode_next;
    end
  end

  // Bus handshake and registered read data, both valid together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack <= access;
      if (access) wb_rdata <= rdata_next;
    end
  end

  // Interrupt outputs all registered from one pending & enable snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq     <= '0;
      irq_any <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq     <= masked;
      irq_any <= |masked;
      irq_id  <= id_next;
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: directed and randomized checks of wb_irq_ctrl against a
// behavioural model of the interrupt controller kept in this bench.
module tb_wb_irq_ctrl;

  localparam int N_SRC = 8;
  localparam int SS    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, wdata;
  logic [3:0]  sel;
  logic [31:0] rdata;
  logic        ack, err, rty;
  logic [7:0]  src;
  logic [7:0]  irq;
  logic        irq_any;
  logic [3:0]  irq_id;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [31:0] exp_b2b [4] = '{32'h0000_00A0, 32'h0000_00FF, 32'h0000_5555, 32'h0000_00A4};

  always #5 clk = ~clk;

  wb_irq_ctrl #(.N_SRC(N_SRC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_sel(sel),
    .wb_wdata(wdata), .wb_rdata(rdata), .wb_ack(ack), .wb_err(err), .wb_rty(rty),
    .src(src), .irq(irq), .irq_any(irq_any), .irq_id(irq_id)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] v);
    src = v;
  endtask

  // Bus access started at the current (negedge) time; waits a bounded time for ack.
  task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] q);
    bit got;
    got = 1'b0;
    q   = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdata = d; sel = s;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        q   = rdata;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    checkOutput("ack_seen", 32'(got), 32'h1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, a, d, 4'hF, dummy);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] q);
    wb_access(1'b0, a, 32'h0, 4'hF, q);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0]  m_pend = '0, m_en = '0, m_last = '0, m_irq = '0;
  logic [15:0] m_mode = '0;
  logic        m_ack = 1'b0, m_any = 1'b0;
  logic [3:0]  m_id = '0;
  logic [31:0] m_rdata = '0;
  logic [7:0]  hist [$];

  function automatic logic [3:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 4'(i);
    return 4'h0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [7:0]  s_now, newp, clr, new_en;
    logic [15:0] new_mode;
    logic [31:0] bm;
    int          md;
    bit          hit;
    if (rst) begin
      m_pend = '0; m_en = '0; m_last = '0; m_irq = '0; m_mode = '0;
      m_ack = 1'b0; m_any = 1'b0; m_id = '0; m_rdata = '0;
      hist.delete();
    end else begin
      // s is the source value seen SS clock edges ago
      if (SS == 0) s_now = src;
      else if (hist.size() >= SS) s_now = hist[hist.size() - SS];
      else s_now = 8'h00;
      hist.push_back(src);
      if (hist.size() > SS + 1) void'(hist.pop_front());

      m_irq = m_pend & m_en;
      m_any = (m_irq != 8'h00);
      m_id  = lowest(m_irq);

      bm       = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      clr      = '0;
      new_en   = m_en;
      new_mode = m_mode;
      if (cyc && stb && !m_ack) begin
        case (adr[3:2])
          2'd0: m_rdata = {24'h0, m_pend};
          2'd1: m_rdata = {24'h0, m_en};
          2'd2: m_rdata = {16'h0, m_mode};
          default: m_rdata = {24'h0, s_now};
        endcase
        if (we) begin
          case (adr[3:2])
            2'd0: clr = wdata[7:0] & bm[7:0];
            2'd1: new_en = (m_en & ~bm[7:0]) | (wdata[7:0] & bm[7:0]);
            2'd2: new_mode = (m_mode & ~bm[15:0]) | (wdata[15:0] & bm[15:0]);
            default: ;
          endcase
        end
      end
      m_ack = cyc && stb && !m_ack;

      for (int i = 0; i < 8; i++) begin
        md = int'((m_mode >> (2 * i)) & 16'h3);
        hit = (md == 1 && s_now[i] && !m_last[i]) ||
              (md == 2 && !s_now[i] && m_last[i]) ||
              (md == 3 && (s_now[i] != m_last[i]));
        if (md == 0) newp[i] = s_now[i];
        else if (hit) newp[i] = 1'b1;
        else if (clr[i]) newp[i] = 1'b0;
        else newp[i] = m_pend[i];
      end
      m_pend = newp;
      m_en   = new_en;
      m_mode = new_mode;
      m_last = s_now;
    end
  end

  // Compare every observable output with the model away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("mon_irq", 32'(irq), 32'(m_irq));
      checkOutput("mon_irq_any", 32'(irq_any), 32'(m_any));
      checkOutput("mon_irq_id", 32'(irq_id), 32'(m_id));
      checkOutput("mon_ack", 32'(ack), 32'(m_ack));
      checkOutput("mon_err_rty", 32'({err, rty}), 32'h0);
      if (ack) checkOutput("mon_rdata", rdata, m_rdata);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] q, r_adr, r_dat, r_sel, r_ctl;
    int          idx;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdata = '0; sel = '0;
    applyStimulus(8'hFF);
    repeat (3) @(negedge clk);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    checkOutput("reset_irq_id", 32'(irq_id), 32'h0);
    checkOutput("reset_ack", 32'(ack), 32'h0);
    mon_en = 1'b1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    wb_read(32'h0, q);
    checkOutput("level_status", q, 32'h0000_00FF);

    // rising edge latency and W1C with source held high
    applyStimulus(8'h00);
    repeat (4) @(negedge clk);
    wb_write(32'h8, 32'h0000_0001);
    wb_write(32'h4, 32'h0000_0001);
    wb_write(32'h0, 32'h0000_00FF);
    applyStimulus(8'h01);
    repeat (SS + 1) @(negedge clk);
    checkOutput("rise_early", 32'(irq), 32'h0);
    @(negedge clk);
    checkOutput("rise_irq", 32'(irq), 32'h01);
    checkOutput("rise_any", 32'(irq_any), 32'h1);
    wb_write(32'h0, 32'h0000_0001);
    @(negedge clk);
    checkOutput("w1c_clear", 32'(irq), 32'h0);
    repeat (5) @(negedge clk);
    checkOutput("w1c_stays", 32'(irq), 32'h0);

    // set event and W1C committed on the same edge
    applyStimulus(8'h00);
    repeat (4) @(negedge clk);
    wb_write(32'h8, 32'h0000_000C);
    wb_write(32'h4, 32'h0000_0002);
    wb_write(32'h0, 32'h0000_00FF);
    @(negedge clk);
    applyStimulus(8'h02);
    repeat (SS) @(negedge clk);
    wb_write(32'h0, 32'h0000_0002);
    wb_read(32'h0, q);
    checkOutput("collision_status", q, 32'h0000_0002);
    checkOutput("collision_id", 32'(irq_id), 32'h1);

    // priority and gating
    applyStimulus(8'h00);
    repeat (4) @(negedge clk);
    wb_write(32'h8, 32'h0000_5555);
    wb_write(32'h0, 32'h0000_00FF);
    wb_write(32'h4, 32'h0000_00A0);
    applyStimulus(8'hA4);
    repeat (SS + 3) @(negedge clk);
    checkOutput("prio_irq", 32'(irq), 32'hA0);
    checkOutput("prio_id5", 32'(irq_id), 32'h5);
    wb_write(32'h4, 32'h0000_00FF);
    @(negedge clk);
    checkOutput("prio_irq_all", 32'(irq), 32'hA4);
    checkOutput("prio_id2", 32'(irq_id), 32'h2);
    wb_write(32'h0, 32'h0000_0004);
    @(negedge clk);
    checkOutput("prio_after_w1c", 32'(irq_id), 32'h5);

    // back-to-back reads with strobe held: ack on alternate cycles
    @(negedge clk);
    idx = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput("b2b_ack", 32'(ack), 32'((k % 2) == 0));
      if (ack && idx < 4) begin
        checkOutput("b2b_rdata", rdata, exp_b2b[idx]);
        idx++;
        adr = 32'(idx * 4);
      end
    end
    cyc = 1'b0; stb = 1'b0;
    checkOutput("b2b_count", 32'(idx), 32'h4);

    wb_write(32'hC, 32'hFFFF_FFFF);
    wb_read(32'hC, q);
    checkOutput("raw_ro", q, 32'h0000_00A4);
    wb_write(32'h4, 32'h0000_0000);
    wb_access(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0001, q);
    wb_read(32'h4, q);
    checkOutput("sel_enable", q, 32'h0000_00FF);
    wb_access(1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0010, q);
    wb_read(32'h8, q);
    checkOutput("sel_mode", q, 32'h0000_FF55);

    // reset during a write before ack: write discarded
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; wdata = 32'h0000_00FF; sel = 4'hF;
    #2 rst = 1'b1;
    #1 checkOutput("rst_ack_low", 32'(ack), 32'h0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    wb_read(32'h4, q);
    checkOutput("rst_enable_cleared", q, 32'h0);
    checkOutput("rst_irq_cleared", 32'(irq), 32'h0);

    // reset while ack is high: ack drops without waiting for a clock
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
    @(negedge clk);
    checkOutput("ack_before_rst", 32'(ack), 32'h1);
    #1 rst = 1'b1;
    #1 checkOutput("ack_async_drop", 32'(ack), 32'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized traffic checked by the monitor against the model
    for (int it = 0; it < 400; it++) begin
      r_ctl = $urandom_range(0, 3);
      if (r_ctl == 0) begin
        r_dat = $urandom();
        applyStimulus(src ^ r_dat[7:0]);
        @(negedge clk);
      end else if (r_ctl == 1) begin
        r_adr = $urandom();
        r_dat = $urandom();
        r_sel = $urandom();
        wb_access(r_dat[31] ^ r_dat[0], r_adr, r_dat, r_sel[3:0], q);
      end else if (r_ctl == 2) begin
        r_adr = $urandom();
        r_dat = $urandom();
        wb_access(1'b1, {r_adr[31:4], 2'b01, r_adr[1:0]}, r_dat, 4'hF, q);
      end else begin
        @(negedge clk);
      end
    end
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
- Wishbone-B3 slave interrupt controller that replaces the ad-hoc per-source edge/change detectors in front of the processor's interrupt vector.
- Each source is synchronised and edge/level-detected according to a software-programmed mode. A sticky pending bit is set per source and gated by a per-source enable.
- Drives the processor interrupt lines plus an encoded highest-priority source ID.
- Sits on the expander as one more slave; its output replaces the hand-built interrupt concatenation.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16).
- SYNC_STAGES, 2, synchroniser flops per source (0 = inputs already in clk domain).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus  slave  wishbone_b3  register interface (32-bit data; adr[3:2] decoded, upper bits ignored).
- src  input  N_SRC  raw interrupt sources.
- irq  output  N_SRC  per-source interrupt request, equal to pending & enable.
- irq_any  output  1  OR of irq.
- irq_id  output  4  index of the lowest-numbered asserted irq bit; 0 when none.

Behaviour:
- Reset:
  - pending, enable, mode, synchroniser and last-sample registers all clear to 0.
  - irq, irq_any, irq_id and bus ack are 0.
- Sync path: src passes through SYNC_STAGES flops to give s. last <= s every cycle.
- MODE register: 2 bits per source i at bits [2i+1:2i].
  - 00 level: pending_i follows s_i each cycle; write-1-clear has no lasting effect while s_i=1.
  - 01 rising: set when s_i & ~last_i.
  - 10 falling: set when ~s_i & last_i.
  - 11 change: set when s_i ^ last_i.
- Edge modes are sticky. A bit clears only on write-1-clear (W1C) to STATUS.
- Simultaneous set event and W1C of the same bit in one cycle: set wins, so the bit stays 1.
- Changing MODE does not clear pending. No spurious edge is generated by the change, because last keeps tracking s regardless of mode.
- Registers (byte offset):
  - 0x0 STATUS: read pending; write-1-clear.
  - 0x4 ENABLE: read/write.
  - 0x8 MODE: read/write.
  - 0xC RAW: read-only s; writes ignored.
  - Unused high bits read 0. Writes honour sel byte lanes.
- Bus handshake:
  - ack <= cyc & stb & ~ack. Exactly one wait state per access; back-to-back strobes get ack every other cycle.
  - dat_o is registered and valid with ack. err and rty are tied 0.
  - Register writes take effect on the cycle ack is asserted.
- Outputs:
  - irq, irq_any and irq_id are registered from pending & enable: one cycle after pending changes.
  - Total latency from a src edge to irq is SYNC_STAGES+2 cycles (detect/pending, then output register).
- Priority: fixed, lowest index wins. irq_id is computed from the same pending & enable value as irq, so the two are coherent in every cycle.
- Disabled sources still latch pending. Setting the enable later raises irq on the following cycle.
- Reset asserted mid-transfer: ack drops immediately (async), all state is cleared, and the in-flight write is discarded.

Test Plan:
- Reset behaviour: assert rst with src=8'hFF and MODE=0 → irq=0, irq_id=0; read STATUS after release → tracks 8'hFF one cycle later (level mode).
- Rising edge: MODE=16'h0001, ENABLE=1, src[0] 0→1 → irq[0]=1 exactly SYNC_STAGES+2 cycles later; hold src high and W1C STATUS=1 → irq[0]=0 and stays 0.
- Set/clear collision: MODE[3:2]=11, ENABLE=2; toggle src[1] so its detect cycle coincides with the ack cycle of a W1C STATUS=2 → STATUS reads 2.
- Priority and gating:
  - Pend sources 2, 5 and 7 with ENABLE=8'hA0 → irq=8'hA0, irq_id=5.
  - Write ENABLE=8'hFF → next cycle irq_id=2.
  - W1C 4 → irq_id=5.
- Bus timing: back-to-back reads of 0x0/0x4/0x8/0xC with stb held → ack pulses on alternate cycles. A write to RAW is ignored. A sel=4'b0001 write of 32'hFFFFFFFF to ENABLE → reads 8'hFF, upper bytes 0.
- Async reset mid-transfer: assert rst during an ENABLE write before ack → ack=0 the same cycle, ENABLE reads 0 after release.
